// File: rtl/pc_sequencer_if.sv
// Instruction-fetch handshake between pc_sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch FSM, next-pc selection and optional return stack.
// Define PC_RETURN_STACK_EN to enable the call/return stack; without it call acts as jump.
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RS_DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  pc_sequencer_if.master     imem,
  output logic               instr_valid,
  input  logic               stall,
  input  logic               halt,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               call,
  input  logic               ret,
  input  logic signed [15:0] branch_offset,
  input  logic        [15:0] jump_target,
  output logic        [15:0] pc,
  output logic               rs_ovf,
  output logic               rs_unf,
  output logic        [1:0]  state
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_e;

  if (RS_DEPTH < 2 || RS_DEPTH > 16 || (RS_DEPTH & (RS_DEPTH - 1)) != 0) begin : g_bad_rs_depth
    $error("pc_sequencer: RS_DEPTH must be a power of two in 2..16");
  end

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        req;
  logic        ack;
  logic [15:0] pc_inc;
  logic [15:0] pc_br;

  // Request depends on stall combinationally so a stalled FETCH never issues.
  assign req            = (state_q == WAIT) || ((state_q == FETCH) && !stall);
  assign ack            = req && imem.imem_ack;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  assign pc_inc = pc_q + 16'd1;
  assign pc_br  = pc_inc + $unsigned(branch_offset);

`ifdef PC_RETURN_STACK_EN
  localparam int              RS_AW      = $clog2(RS_DEPTH);
  localparam logic [RS_AW:0]  RS_FULL    = RS_DEPTH;
  localparam logic [RS_AW:0]  RS_CNT_ONE = 1;
  localparam logic [RS_AW-1:0] RS_PTR_ONE = 1;

  logic [15:0]      rs_mem_q [RS_DEPTH];
  logic [RS_AW-1:0] rs_ptr_q, rs_ptr_d, rs_ptr_dec;
  logic [RS_AW:0]   rs_cnt_q, rs_cnt_d;
  logic             rs_ovf_q, rs_ovf_d;
  logic             rs_unf_q, rs_unf_d;
  logic             rs_push, rs_pop, rs_empty;

  // Circular buffer: a push when full overwrites the oldest entry in place.
  assign rs_ptr_dec = rs_ptr_q - RS_PTR_ONE;
  assign rs_empty   = (rs_cnt_q == '0);
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = ack;
`ifdef PC_RETURN_STACK_EN
    rs_push       = 1'b0;
    rs_pop        = 1'b0;
`endif

    case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, WAIT: begin
        if (ack)      state_d = halt ? HALT : FETCH;
        else if (req) state_d = WAIT;
      end
      default:     state_d = HALT;
    endcase

    if (ack && !halt) begin
      if (jump) begin
        pc_d = jump_target;
      end else if (call) begin
        pc_d = jump_target;
`ifdef PC_RETURN_STACK_EN
        rs_push = 1'b1;
`endif
      end else if (ret) begin
`ifdef PC_RETURN_STACK_EN
        rs_pop = 1'b1;
        pc_d   = rs_empty ? pc_inc : rs_mem_q[rs_ptr_dec];
`else
        pc_d   = pc_inc;
`endif
      end else if (branch_taken) begin
        pc_d = pc_br;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

`ifdef PC_RETURN_STACK_EN
  always_comb begin
    rs_ptr_d = rs_ptr_q;
    rs_cnt_d = rs_cnt_q;
    rs_ovf_d = rs_ovf_q;
    rs_unf_d = rs_unf_q;
    if (rs_push) begin
      rs_ptr_d = rs_ptr_q + RS_PTR_ONE;
      if (rs_cnt_q == RS_FULL) rs_ovf_d = 1'b1;
      else                     rs_cnt_d = rs_cnt_q + RS_CNT_ONE;
    end else if (rs_pop) begin
      if (rs_empty) begin
        rs_unf_d = 1'b1;
      end else begin
        rs_ptr_d = rs_ptr_dec;
        rs_cnt_d = rs_cnt_q - RS_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rs_push) rs_mem_q[rs_ptr_q] <= pc_inc;
  end

  assign rs_ovf = rs_ovf_q;
  assign rs_unf = rs_unf_q;
`else
  assign rs_ovf = 1'b0;
  assign rs_unf = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      instr_valid_q <= 1'b0;
`ifdef PC_RETURN_STACK_EN
      rs_ptr_q      <= '0;
      rs_cnt_q      <= '0;
      rs_ovf_q      <= 1'b0;
      rs_unf_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef PC_RETURN_STACK_EN
      rs_ptr_q      <= rs_ptr_d;
      rs_cnt_q      <= rs_cnt_d;
      rs_ovf_q      <= rs_ovf_d;
      rs_unf_q      <= rs_unf_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign state       = state_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed stimulus plus a next-pc scoreboard
// filled on every ack cycle and drained on every instr_valid pulse.
module tb_pc_sequencer;

  localparam int RS_D = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               instr_valid;
  logic               stall, halt, branch_taken, jump, call, ret;
  logic signed [15:0] branch_offset;
  logic        [15:0] jump_target;
  logic        [15:0] pc;
  logic               rs_ovf, rs_unf;
  logic        [1:0]  state;

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_VECTOR(16'h0000), .RS_DEPTH(RS_D)) u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem          (imem_if.master),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .pc            (pc),
    .rs_ovf        (rs_ovf),
    .rs_unf        (rs_unf),
    .state         (state)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] sb_q [$];
  logic [15:0] m_rs [$];
  logic [15:0] m_pc  = 16'h0000;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  function automatic logic [15:0] model_next();
    logic [15:0] inc;
    inc = m_pc + 16'd1;
    if (halt) return m_pc;
    if (jump) return jump_target;
`ifdef PC_RETURN_STACK_EN
    if (call) begin
      m_rs.push_back(inc);
      if (m_rs.size() > RS_D) begin
        void'(m_rs.pop_front());
        m_ovf = 1'b1;
      end
      return jump_target;
    end
    if (ret) begin
      if (m_rs.size() == 0) begin
        m_unf = 1'b1;
        return inc;
      end
      return m_rs.pop_back();
    end
`else
    if (call) return jump_target;
    if (ret)  return inc;
`endif
    if (branch_taken) return inc + $unsigned(branch_offset);
    return inc;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      sb_q.delete();
      m_rs.delete();
      m_pc  = 16'h0000;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      chk("addr_vs_model", 32'(imem_if.imem_addr), 32'(m_pc));
      chk("ovf_vs_model", 32'(rs_ovf), 32'(m_ovf));
      chk("unf_vs_model", 32'(rs_unf), 32'(m_unf));
      if (instr_valid) begin
        if (sb_q.size() == 0) chk("sb_underrun", sb_q.size(), 1);
        else                  chk("sb_pc", 32'(pc), 32'(sb_q.pop_front()));
      end
      if (imem_if.imem_req && imem_if.imem_ack) begin
        m_pc = model_next();
        sb_q.push_back(m_pc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] ret_exp [5];
    ret_exp = '{16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0003};

    reset_n          = 1'b0;
    stall            = 1'b0;
    halt             = 1'b0;
    branch_taken     = 1'b0;
    jump             = 1'b0;
    call             = 1'b0;
    ret              = 1'b0;
    branch_offset    = 16'sh0000;
    jump_target      = 16'h0000;
    imem_if.imem_ack = 1'b0;
    repeat (2) step();

    chk("rst_pc", 32'(pc), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_req", 32'(imem_if.imem_req), 0);
    chk("rst_iv", 32'(instr_valid), 0);
    chk("rst_ovf", 32'(rs_ovf), 0);
    chk("rst_unf", 32'(rs_unf), 0);

    // Reset release with ack held high: one BOOT cycle, then a fetch per cycle
    imem_if.imem_ack = 1'b1;
    reset_n          = 1'b1;
    #1 chk("boot_state", 32'(state), 0);
    chk("boot_req", 32'(imem_if.imem_req), 0);
    step();
    chk("f0_state", 32'(state), 1);
    chk("f0_pc", 32'(pc), 'h0000);
    chk("f0_iv", 32'(instr_valid), 0);
    step();
    chk("f1_pc", 32'(pc), 'h0001);
    chk("f1_iv", 32'(instr_valid), 1);
    step();
    chk("f2_pc", 32'(pc), 'h0002);
    chk("f2_iv", 32'(instr_valid), 1);

    // Negative branch offset and 16-bit wrap
    jump = 1'b1; jump_target = 16'h0010;
    step();
    jump = 1'b0;
    chk("jmp_pc", 32'(pc), 'h0010);
    branch_taken = 1'b1; branch_offset = 16'shFFFC;
    step();
    branch_taken = 1'b0;
    chk("br_neg_pc", 32'(pc), 'h000D);
    jump = 1'b1; jump_target = 16'hFFFF;
    step();
    jump = 1'b0;
    step();
    chk("wrap_pc", 32'(pc), 'h0000);

    // Wait states: ack low for three cycles
    imem_if.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_state", 32'(state), 2);
      chk("wait_req", 32'(imem_if.imem_req), 1);
      chk("wait_pc", 32'(pc), 'h0000);
    end
    imem_if.imem_ack = 1'b1;
    step();
    chk("wait_done_pc", 32'(pc), 'h0001);
    chk("wait_done_state", 32'(state), 1);

    // Stall in FETCH holds; stall in WAIT is ignored
    stall = 1'b1;
    #1 chk("stall_req", 32'(imem_if.imem_req), 0);
    step();
    step();
    chk("stall_pc", 32'(pc), 'h0001);
    chk("stall_state", 32'(state), 1);
    stall = 1'b0; imem_if.imem_ack = 1'b0;
    step();
    chk("sw_state", 32'(state), 2);
    stall = 1'b1;
    #1 chk("sw_req", 32'(imem_if.imem_req), 1);
    imem_if.imem_ack = 1'b1;
    step();
    chk("sw_pc", 32'(pc), 'h0002);
    chk("sw_state_fetch", 32'(state), 1);
    chk("sw_req_stalled", 32'(imem_if.imem_req), 0);
    stall = 1'b0;

`ifdef PC_RETURN_STACK_EN
    jump = 1'b1; jump_target = 16'h0000;
    step();
    jump = 1'b0;
    chk("rs_start_pc", 32'(pc), 'h0000);
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; jump_target = 16'(i + 1);
      step();
      chk("call_pc", 32'(pc), 32'(i + 1));
    end
    call = 1'b0;
    chk("call_ovf", 32'(rs_ovf), 1);
    chk("call_unf", 32'(rs_unf), 0);
    ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ret_pc", 32'(pc), 32'(ret_exp[i]));
    end
    ret = 1'b0;
    chk("ret_unf", 32'(rs_unf), 1);
    chk("ret_ovf", 32'(rs_ovf), 1);
`else
    call = 1'b1; jump_target = 16'h0300;
    step();
    call = 1'b0;
    chk("call_as_jump", 32'(pc), 'h0300);
    chk("ret_exp_unused", 32'(ret_exp[0]), 'h0005);
    ret = 1'b1; branch_taken = 1'b1; branch_offset = 16'sh0010;
    step();
    ret = 1'b0; branch_taken = 1'b0;
    chk("ret_over_branch", 32'(pc), 'h0301);
    chk("nors_ovf", 32'(rs_ovf), 0);
    chk("nors_unf", 32'(rs_unf), 0);
`endif

    // Jump beats branch; halt freezes everything
    jump = 1'b1; branch_taken = 1'b1; jump_target = 16'h0200; branch_offset = 16'sh0005;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    chk("jmp_pri_pc", 32'(pc), 'h0200);
    halt = 1'b1;
    step();
    chk("halt_state", 32'(state), 3);
    chk("halt_req", 32'(imem_if.imem_req), 0);
    chk("halt_iv", 32'(instr_valid), 1);
    chk("halt_pc", 32'(pc), 'h0200);
    halt = 1'b0;
    step();
    step();
    chk("halt_hold_state", 32'(state), 3);
    chk("halt_hold_pc", 32'(pc), 'h0200);
    chk("halt_hold_iv", 32'(instr_valid), 0);

    // Reset leaves HALT; then reset pulsed mid-WAIT
    reset_n = 1'b0;
    #1 chk("hrst_state", 32'(state), 0);
    chk("hrst_pc", 32'(pc), 'h0000);
    step();
    reset_n = 1'b1; jump = 1'b1; jump_target = 16'h1234;
    step();
    chk("r2_state", 32'(state), 1);
    chk("r2_pc", 32'(pc), 'h0000);
    step();
    chk("r2_jmp_pc", 32'(pc), 'h1234);
    jump = 1'b0; imem_if.imem_ack = 1'b0;
    step();
    chk("r3_wait_state", 32'(state), 2);
    chk("r3_wait_req", 32'(imem_if.imem_req), 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_req", 32'(imem_if.imem_req), 0);
    chk("mid_rst_pc", 32'(pc), 'h0000);
    chk("mid_rst_state", 32'(state), 0);
    imem_if.imem_ack = 1'b1;
    step();
    chk("in_rst_state", 32'(state), 0);
    chk("in_rst_req", 32'(imem_if.imem_req), 0);
    reset_n = 1'b1;
    step();
    chk("post_rst_state", 32'(state), 1);
    chk("post_rst_pc", 32'(pc), 'h0000);
    step();
    chk("post_rst_pc1", 32'(pc), 'h0001);

    imem_if.imem_ack = 1'b0;
    step();
    step();
    chk("sb_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter RS_DEPTH, default 4: return-stack entries, power of two, 2..16.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1: fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  16: fetch address, always equal to pc.
REQ-007 SHALL have port imem_ack  input  1: fetch accepted/completed this cycle.
REQ-008 SHALL have port instr_valid  output  1: registered one-cycle pulse, instruction at prior pc delivered.
REQ-009 SHALL have ports stall, halt, branch_taken, jump, call, ret  input  1 each: decode controls.
REQ-010 SHALL have ports branch_offset (signed), jump_target  input  16 each.
REQ-011 SHALL have port pc  output  16: current program counter.
REQ-012 SHALL have ports rs_ovf, rs_unf  output  1 each: sticky return-stack overflow/underflow flags.
REQ-013 SHALL have port state  output  2: FSM state (BOOT=0, FETCH=1, WAIT=2, HALT=3).

Function
REQ-014 SHALL implement FSM BOOT -> FETCH (unconditional, 1 cycle); FETCH -> WAIT when imem_req=1 and imem_ack=0; WAIT -> FETCH on imem_ack=1; any non-HALT state -> HALT when halt=1 at an ack; HALT exits only via reset.
REQ-015 SHALL drive imem_req=1 in FETCH (unless stall=1) and in WAIT; 0 in BOOT and HALT.
REQ-016 SHALL update pc only on a cycle with imem_req=1 and imem_ack=1 ("ack cycle"); all decode controls are sampled on the ack cycle only.
REQ-017 SHALL select next pc with priority halt (hold) > jump (jump_target) > call > ret > branch_taken (pc+1+branch_offset) > pc+1.
REQ-018 SHALL hold pc and deassert imem_req for every FETCH cycle with stall=1; stall is ignored in WAIT (request stays asserted until ack).
REQ-019 SHALL compute all pc arithmetic modulo 2^16: 16'hFFFF+1 = 16'h0000; negative offsets wrap.
REQ-020 SHALL assert instr_valid for exactly the cycle after each ack cycle, including the ack that enters HALT.
REQ-021 SHALL sustain one fetch per cycle when imem_ack is held high and stall=0 (zero-wait throughput).

Reset
REQ-022 SHALL on reset_n=0, asynchronously: pc=RESET_VECTOR, state=BOOT, imem_req=0, instr_valid=0, rs_ovf=0, rs_unf=0, return stack empty.
REQ-023 SHALL, on reset asserted mid-WAIT, drop imem_req immediately and discard the outstanding fetch; an ack arriving during or after reset is ignored until FETCH is re-entered.

Configuration
REQ-024 SHALL with PC_RETURN_STACK_EN defined: call pushes pc+1 and loads jump_target; ret pops into pc; push when full discards oldest entry and sets rs_ovf; pop when empty yields pc+1 and sets rs_unf; call and ret together treated as call.
REQ-025 SHALL without PC_RETURN_STACK_EN: no stack storage; call behaves as jump; ret behaves as pc+1; rs_ovf and rs_unf tied 0.

Verification
REQ-026 SHALL cover: reset release, imem_ack=1 constant -> BOOT one cycle, then pc 0000,0001,0002 on consecutive cycles, instr_valid high from third cycle after release.
REQ-027 SHALL cover: pc=16'h0010, branch_taken=1, branch_offset=16'hFFFC at ack -> pc=16'h000D; pc=16'hFFFF with no control -> 16'h0000.
REQ-028 SHALL cover: imem_ack held low 3 cycles -> state WAIT, imem_req stays 1, pc unchanged; ack on 4th cycle -> pc+1, state FETCH.
REQ-029 SHALL cover: jump=1, branch_taken=1, jump_target=16'h0200 same ack -> pc=16'h0200; halt=1 at ack -> state HALT, imem_req=0, pc frozen until reset_n low.
REQ-030 SHALL cover (macro on, RS_DEPTH=4): 5 nested calls from pc 0x0000..0x0004 then 5 rets -> first 4 rets return 0x0005,0x0004,0x0003,0x0002; 5th ret gives pc+1; rs_ovf=1 and rs_unf=1.
REQ-031 SHALL cover: reset_n pulsed low during WAIT -> imem_req=0 within same cycle, pc=RESET_VECTOR, state=BOOT.
